// File: rtl/crossbarx_stream2_sched_pkg.sv
// Shared width helpers, MVB item packing and popcount for the CrossbarX Stream2 scheduler.
package crossbarx_stream2_sched_pkg;

    function automatic int pid_w(input int ports);
        return (ports <= 2) ? 1 : $clog2(ports);
    endfunction

    function automatic int item_w(input int ports, input int len_w);
        return pid_w(ports) + len_w;
    endfunction

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    function automatic logic [63:0] item_pack(input logic [31:0] pid, input logic [31:0] len,
                                              input int len_w);
        return (64'(pid) << len_w) | 64'(len);
    endfunction

    function automatic logic [31:0] item_pid(input logic [63:0] item, input int len_w);
        return 32'(item >> len_w);
    endfunction

    function automatic logic [31:0] item_len(input logic [63:0] item, input int len_w);
        return 32'(item & ((64'd1 << len_w) - 64'd1));
    endfunction

    // Vectors up to 32 bits; ITEMS never exceeds that in practice.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/crossbarx_stream2_sched_sel.sv
// Round-robin selector: scans requests from the pointer and picks the first K (K <= limit).
module crossbarx_stream2_sched_sel
    import crossbarx_stream2_sched_pkg::*;
#(
    parameter int REQ_PORTS = 4,
    parameter int ITEMS     = 2,
    parameter int PID_W     = 2,
    parameter int KW        = 2
) (
    input  logic [REQ_PORTS-1:0]   i_req,
    input  logic [PID_W-1:0]       i_rr_ptr,
    input  logic [KW-1:0]          i_kmax,
    output logic [REQ_PORTS-1:0]   o_grant,
    output logic [ITEMS*PID_W-1:0] o_idx,
    output logic [KW-1:0]          o_k
);

    logic [PID_W:0]   w_sum;
    logic [PID_W-1:0] w_p;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_k     = '0;
        w_sum   = '0;
        w_p     = '0;
        for (int i = 0; i < REQ_PORTS; i++) begin
            w_sum = {1'b0, i_rr_ptr} + (PID_W+1)'(i);
            if (w_sum >= (PID_W+1)'(REQ_PORTS)) begin
                w_sum = w_sum - (PID_W+1)'(REQ_PORTS);
            end
            w_p = w_sum[PID_W-1:0];
            if (i_req[w_p] && (o_k < i_kmax)) begin
                o_grant[w_p] = 1'b1;
                for (int k = 0; k < ITEMS; k++) begin
                    if (KW'(k) == o_k) begin
                        o_idx[k*PID_W +: PID_W] = w_p;
                    end
                end
                o_k = o_k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbarx_stream2_sched.sv
// Per-packet round-robin scheduler feeding the CrossbarX RX MVB instruction stream,
// with a completion-refilled credit counter bounding in-flight packets.
module crossbarx_stream2_sched
    import crossbarx_stream2_sched_pkg::*;
#(
    parameter int REQ_PORTS       = 4,
    parameter int ITEMS           = 2,
    parameter int LEN_W           = 15,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic                                         ENABLE,
    input  logic [REQ_PORTS*LEN_W-1:0]                   REQ_LEN,
    input  logic [REQ_PORTS-1:0]                         REQ_SRC_RDY,
    output logic [REQ_PORTS-1:0]                         REQ_DST_RDY,
    output logic [ITEMS*item_w(REQ_PORTS, LEN_W)-1:0]    TX_MVB_DATA,
    output logic [ITEMS-1:0]                             TX_MVB_VLD,
    output logic                                         TX_MVB_SRC_RDY,
    input  logic                                         TX_MVB_DST_RDY,
    input  logic [ITEMS-1:0]                             DONE_VLD,
    output logic [cnt_w(MAX_OUTSTANDING)-1:0]            OUTSTANDING,
    output logic                                         ERR_UNDERFLOW
);

    localparam int PID_W  = pid_w(REQ_PORTS);
    localparam int ITEM_W = PID_W + LEN_W;
    localparam int CNT_W  = cnt_w(MAX_OUTSTANDING);
    localparam int KW     = $clog2(ITEMS + 1);

    logic [1:0]              r_rst_sync;
    logic                    w_rst_busy;
    logic                    r_src_rdy;
    logic [ITEMS-1:0]        r_vld;
    logic [ITEMS*ITEM_W-1:0] r_data;
    logic [PID_W-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]        r_outstanding;
    logic                    r_err;

    logic                    w_load;
    logic [CNT_W-1:0]        w_avail;
    logic [KW-1:0]           w_kmax;
    logic [KW-1:0]           w_k;
    logic [REQ_PORTS-1:0]    w_grant;
    logic [ITEMS*PID_W-1:0]  w_idx;
    logic [PID_W-1:0]        w_pid;
    logic [ITEMS*ITEM_W-1:0] w_data;
    logic [ITEMS-1:0]        w_vld;
    logic [PID_W-1:0]        w_rr_next;
    logic [CNT_W:0]          w_cnt_sum;
    logic [CNT_W:0]          w_done_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_underflow;

    // Reset asserts immediately but its release is aligned to CLK.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_rst_sync <= 2'b11;
        else       r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
    assign w_rst_busy = r_rst_sync[1];

    assign w_load  = ENABLE && !w_rst_busy && (!r_src_rdy || TX_MVB_DST_RDY);
    assign w_avail = CNT_W'(MAX_OUTSTANDING) - r_outstanding;

    always_comb begin
        w_kmax = '0;
        if (w_load) begin
            w_kmax = (w_avail >= CNT_W'(ITEMS)) ? KW'(ITEMS) : KW'(w_avail);
        end
    end

    crossbarx_stream2_sched_sel #(
        .REQ_PORTS (REQ_PORTS),
        .ITEMS     (ITEMS),
        .PID_W     (PID_W),
        .KW        (KW)
    ) u_sel (
        .i_req    (REQ_SRC_RDY),
        .i_rr_ptr (r_rr_ptr),
        .i_kmax   (w_kmax),
        .o_grant  (w_grant),
        .o_idx    (w_idx),
        .o_k      (w_k)
    );

    always_comb begin
        w_data    = '0;
        w_vld     = '0;
        w_pid     = '0;
        w_rr_next = r_rr_ptr;
        for (int k = 0; k < ITEMS; k++) begin
            w_pid = w_idx[k*PID_W +: PID_W];
            if (KW'(k) < w_k) begin
                w_data[k*ITEM_W +: ITEM_W] =
                    ITEM_W'(item_pack(32'(w_pid), 32'(REQ_LEN[w_pid*LEN_W +: LEN_W]), LEN_W));
                w_vld[k] = 1'b1;
            end
            if (KW'(k + 1) == w_k) begin
                w_rr_next = (w_pid == PID_W'(REQ_PORTS - 1)) ? '0 : w_pid + 1'b1;
            end
        end
    end

    // Grants and completions in the same cycle are netted; excess completions clamp at 0.
    always_comb begin
        w_cnt_sum   = {1'b0, r_outstanding} + (CNT_W+1)'(w_k);
        w_done_cnt  = (CNT_W+1)'(popcount(32'(DONE_VLD)));
        w_underflow = 1'b0;
        w_cnt_next  = CNT_W'(w_cnt_sum - w_done_cnt);
        if (w_done_cnt > w_cnt_sum) begin
            w_underflow = 1'b1;
            w_cnt_next  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET || w_rst_busy) begin
            r_src_rdy     <= 1'b0;
            r_vld         <= '0;
            r_data        <= '0;
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_load) begin
                r_data    <= w_data;
                r_vld     <= w_vld;
                r_src_rdy <= (w_k != '0);
                r_rr_ptr  <= w_rr_next;
            end else if (r_src_rdy && TX_MVB_DST_RDY) begin
                r_src_rdy <= 1'b0;
            end
            r_outstanding <= w_cnt_next;
            if (w_underflow) r_err <= 1'b1;
        end
    end

    assign REQ_DST_RDY    = w_grant;
    assign TX_MVB_DATA    = r_data;
    assign TX_MVB_VLD     = r_vld;
    assign TX_MVB_SRC_RDY = r_src_rdy;
    assign OUTSTANDING    = r_outstanding;
    assign ERR_UNDERFLOW  = r_err;

endmodule

// File: tb/tb_crossbarx_stream2_sched.sv
// Directed bench for crossbarx_stream2_sched: rotation, credits, back-pressure, underflow, reset.
module tb_crossbarx_stream2_sched;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [59:0] REQ_LEN;
    logic [3:0]  REQ_SRC_RDY;
    logic [3:0]  REQ_DST_RDY;
    logic [33:0] TX_MVB_DATA;
    logic [1:0]  TX_MVB_VLD;
    logic        TX_MVB_SRC_RDY;
    logic        TX_MVB_DST_RDY;
    logic [1:0]  DONE_VLD;
    logic [5:0]  OUTSTANDING;
    logic        ERR_UNDERFLOW;

    int n_cmp = 0;
    int n_err = 0;

    crossbarx_stream2_sched #(
        .REQ_PORTS       (4),
        .ITEMS           (2),
        .LEN_W           (15),
        .MAX_OUTSTANDING (32)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .REQ_LEN        (REQ_LEN),
        .REQ_SRC_RDY    (REQ_SRC_RDY),
        .REQ_DST_RDY    (REQ_DST_RDY),
        .TX_MVB_DATA    (TX_MVB_DATA),
        .TX_MVB_VLD     (TX_MVB_VLD),
        .TX_MVB_SRC_RDY (TX_MVB_SRC_RDY),
        .TX_MVB_DST_RDY (TX_MVB_DST_RDY),
        .DONE_VLD       (DONE_VLD),
        .OUTSTANDING    (OUTSTANDING),
        .ERR_UNDERFLOW  (ERR_UNDERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [16:0] itm(input int pid, input int len);
        return 17'((pid << 15) | len);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET          = 1'b1;
        ENABLE         = 1'b0;
        REQ_LEN        = {15'd67, 15'd66, 15'd65, 15'd64};
        REQ_SRC_RDY    = 4'b0000;
        TX_MVB_DST_RDY = 1'b0;
        DONE_VLD       = 2'b00;
        step();
        step();
        chk("rst_src_rdy", 64'(TX_MVB_SRC_RDY), 64'd0);
        chk("rst_vld", 64'(TX_MVB_VLD), 64'd0);
        chk("rst_data", 64'(TX_MVB_DATA), 64'd0);
        chk("rst_outstanding", 64'(OUTSTANDING), 64'd0);
        chk("rst_err", 64'(ERR_UNDERFLOW), 64'd0);
        RESET = 1'b0;
        step();
        step();
        step();

        // strict rotation with all ports requesting
        ENABLE         = 1'b1;
        TX_MVB_DST_RDY = 1'b1;
        REQ_SRC_RDY    = 4'b1111;
        #2;
        chk("rot_grant0", 64'(REQ_DST_RDY), 64'b0011);
        step();
        chk("rot_word1", 64'(TX_MVB_DATA), 64'({itm(1, 65), itm(0, 64)}));
        chk("rot_vld1", 64'(TX_MVB_VLD), 64'b11);
        chk("rot_src1", 64'(TX_MVB_SRC_RDY), 64'd1);
        chk("rot_out1", 64'(OUTSTANDING), 64'd2);
        chk("rot_grant1", 64'(REQ_DST_RDY), 64'b1100);
        step();
        chk("rot_word2", 64'(TX_MVB_DATA), 64'({itm(3, 67), itm(2, 66)}));
        chk("rot_out2", 64'(OUTSTANDING), 64'd4);
        step();
        chk("rot_word3", 64'(TX_MVB_DATA), 64'({itm(1, 65), itm(0, 64)}));
        chk("rot_out3", 64'(OUTSTANDING), 64'd6);

        // run to credit exhaustion (16 full words)
        for (int n = 4; n <= 16; n++) begin
            step();
            chk("fill_out", 64'(OUTSTANDING), 64'(2 * n));
            if (n % 2 == 0) chk("fill_word", 64'(TX_MVB_DATA), 64'({itm(3, 67), itm(2, 66)}));
            else            chk("fill_word", 64'(TX_MVB_DATA), 64'({itm(1, 65), itm(0, 64)}));
        end
        #2;
        chk("full_no_grant", 64'(REQ_DST_RDY), 64'd0);
        step();
        chk("full_src_drop", 64'(TX_MVB_SRC_RDY), 64'd0);
        chk("full_out", 64'(OUTSTANDING), 64'd32);
        DONE_VLD = 2'b01;
        #2;
        chk("done_cycle_no_grant", 64'(REQ_DST_RDY), 64'd0);
        step();
        DONE_VLD = 2'b00;
        chk("done_out", 64'(OUTSTANDING), 64'd31);
        #2;
        chk("one_credit_grant", 64'(REQ_DST_RDY), 64'b0001);
        step();
        chk("one_credit_vld", 64'(TX_MVB_VLD), 64'b01);
        chk("one_credit_src", 64'(TX_MVB_SRC_RDY), 64'd1);
        chk("one_credit_item0", 64'(TX_MVB_DATA[16:0]), 64'(itm(0, 64)));
        chk("one_credit_out", 64'(OUTSTANDING), 64'd32);

        // drain credits with double completions
        REQ_SRC_RDY = 4'b0000;
        DONE_VLD    = 2'b11;
        for (int n = 0; n < 16; n++) step();
        DONE_VLD = 2'b00;
        chk("drain_out", 64'(OUTSTANDING), 64'd0);
        chk("drain_src", 64'(TX_MVB_SRC_RDY), 64'd0);
        chk("drain_err", 64'(ERR_UNDERFLOW), 64'd0);

        // single requester, then same port again from rr_ptr=3
        REQ_SRC_RDY = 4'b0100;
        #2;
        chk("p2_grant_a", 64'(REQ_DST_RDY), 64'b0100);
        step();
        chk("p2_item_a", 64'(TX_MVB_DATA[16:0]), 64'(itm(2, 66)));
        chk("p2_vld_a", 64'(TX_MVB_VLD), 64'b01);
        chk("p2_out_a", 64'(OUTSTANDING), 64'd1);
        REQ_LEN[44:30] = 15'd100;
        #2;
        chk("p2_grant_b", 64'(REQ_DST_RDY), 64'b0100);
        step();
        chk("p2_item_b", 64'(TX_MVB_DATA[16:0]), 64'(itm(2, 100)));
        chk("p2_vld_b", 64'(TX_MVB_VLD), 64'b01);
        chk("p2_out_b", 64'(OUTSTANDING), 64'd2);

        // back-pressure for 5 cycles: held word stable, no grants
        TX_MVB_DST_RDY = 1'b0;
        REQ_SRC_RDY    = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            #2;
            chk("stall_no_grant", 64'(REQ_DST_RDY), 64'd0);
            step();
            chk("stall_item", 64'(TX_MVB_DATA[16:0]), 64'(itm(2, 100)));
            chk("stall_vld", 64'(TX_MVB_VLD), 64'b01);
            chk("stall_src", 64'(TX_MVB_SRC_RDY), 64'd1);
            chk("stall_out", 64'(OUTSTANDING), 64'd2);
        end
        TX_MVB_DST_RDY = 1'b1;
        #2;
        chk("release_grant", 64'(REQ_DST_RDY), 64'b1001);
        step();
        chk("release_word", 64'(TX_MVB_DATA), 64'({itm(0, 64), itm(3, 67)}));
        chk("release_vld", 64'(TX_MVB_VLD), 64'b11);
        chk("release_out", 64'(OUTSTANDING), 64'd4);

        // ENABLE low: held word still drains, nothing new granted
        ENABLE         = 1'b0;
        TX_MVB_DST_RDY = 1'b0;
        #2;
        chk("dis_no_grant", 64'(REQ_DST_RDY), 64'd0);
        step();
        chk("dis_held_src", 64'(TX_MVB_SRC_RDY), 64'd1);
        chk("dis_held_vld", 64'(TX_MVB_VLD), 64'b11);
        TX_MVB_DST_RDY = 1'b1;
        #2;
        chk("dis_drain_no_grant", 64'(REQ_DST_RDY), 64'd0);
        step();
        chk("dis_drained_src", 64'(TX_MVB_SRC_RDY), 64'd0);
        chk("dis_out", 64'(OUTSTANDING), 64'd4);
        REQ_SRC_RDY = 4'b0000;
        ENABLE      = 1'b1;

        // underflow: two completions against one outstanding
        DONE_VLD = 2'b11;
        step();
        chk("uf_out2", 64'(OUTSTANDING), 64'd2);
        DONE_VLD = 2'b01;
        step();
        chk("uf_out1", 64'(OUTSTANDING), 64'd1);
        DONE_VLD = 2'b11;
        step();
        chk("uf_clamp", 64'(OUTSTANDING), 64'd0);
        chk("uf_err_set", 64'(ERR_UNDERFLOW), 64'd1);
        DONE_VLD = 2'b00;
        step();
        chk("uf_err_sticky", 64'(ERR_UNDERFLOW), 64'd1);
        chk("uf_out_hold", 64'(OUTSTANDING), 64'd0);

        // asynchronous reset with a held word and 10 in flight
        REQ_SRC_RDY = 4'b1111;
        for (int n = 0; n < 5; n++) step();
        REQ_SRC_RDY    = 4'b0000;
        TX_MVB_DST_RDY = 1'b0;
        step();
        chk("pre_rst_out", 64'(OUTSTANDING), 64'd10);
        chk("pre_rst_src", 64'(TX_MVB_SRC_RDY), 64'd1);
        chk("pre_rst_err", 64'(ERR_UNDERFLOW), 64'd1);
        #3;
        RESET = 1'b1;
        #1;
        chk("arst_src", 64'(TX_MVB_SRC_RDY), 64'd0);
        chk("arst_vld", 64'(TX_MVB_VLD), 64'd0);
        chk("arst_data", 64'(TX_MVB_DATA), 64'd0);
        chk("arst_out", 64'(OUTSTANDING), 64'd0);
        chk("arst_err", 64'(ERR_UNDERFLOW), 64'd0);
        step();
        step();
        RESET = 1'b0;
        step();
        step();
        step();
        TX_MVB_DST_RDY = 1'b1;
        REQ_SRC_RDY    = 4'b1111;
        #2;
        chk("post_rst_grant", 64'(REQ_DST_RDY), 64'b0011);
        step();
        chk("post_rst_word", 64'(TX_MVB_DATA), 64'({itm(1, 65), itm(0, 64)}));
        chk("post_rst_vld", 64'(TX_MVB_VLD), 64'b11);
        chk("post_rst_out", 64'(OUTSTANDING), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
